// File: rtl/cpu_flags_pkg.sv
// Shared flag/condition definitions for the status-flag stage and branch unit.
// Flag vector ordering is {N,Z,C,V} = bits [3:0].
package cpu_flags_pkg;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Per-flag write masks: logical ops (AND/TST) only touch N and Z.
  localparam logic [3:0] MASK_LOGIC = 4'b1100;
  localparam logic [3:0] MASK_ALL   = 4'b1111;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator, shared with the branch unit.
// Ports:
//   cond_code - 4-bit condition selector (cond_e encoding)
//   flags     - {N,Z,C,V}
//   result    - 1 when the condition holds
module cond_eval
  import cpu_flags_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       result
);

  logic n, z, c, v;

  always_comb begin
    n = flags[N_BIT];
    z = flags[Z_BIT];
    c = flags[C_BIT];
    v = flags[V_BIT];
    result = 1'b0;
    case (cond_code)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = z | (n != v);
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural Z/N/C/V flag register with masked updates, a registered
// branch-condition query (bypassing same-cycle updates), and a shadow stack
// for saving/restoring flags across interrupts.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   upd_valid/upd_flags/upd_mask - masked flag write from the ALU
//   cond_valid/cond_code        - condition query; answered one cycle later
//   push_en/pop_en              - shadow stack save/restore
//   flags                       - current {N,Z,C,V}
//   taken/taken_valid           - registered query result and its strobe
//   stack_cnt                   - occupied stack entries
//   stack_err                   - one-cycle pulse after an illegal stack op
module flag_cond_unit
  import cpu_flags_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int FLAG_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         upd_valid,
  input  logic [FLAG_W-1:0]            upd_flags,
  input  logic [FLAG_W-1:0]            upd_mask,
  input  logic                         cond_valid,
  input  logic [3:0]                   cond_code,
  input  logic                         push_en,
  input  logic                         pop_en,
  output logic [FLAG_W-1:0]            flags,
  output logic                         taken,
  output logic                         taken_valid,
  output logic [$clog2(STACK_DEPTH):0] stack_cnt,
  output logic                         stack_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLAG_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic              full, empty;
  logic              push_ok, pop_ok, op_err;
  logic [FLAG_W-1:0] nf;
  logic              cond_res;

  always_comb begin
    full    = (stack_cnt == CNT_W'(STACK_DEPTH));
    empty   = (stack_cnt == '0);
    wr_idx  = stack_cnt[PTR_W-1:0];
    // When full the low bits wrap to 0, so top_idx still lands on the last slot.
    top_idx = stack_cnt[PTR_W-1:0] - PTR_W'(1);
    push_ok = push_en & ~pop_en & ~full;
    pop_ok  = pop_en & ~push_en & ~empty;
    op_err  = (push_en & pop_en) | (push_en & full) | (pop_en & empty);

    // An interrupt return overrides any same-cycle ALU update.
    if (pop_ok)
      nf = stack_mem[top_idx];
    else if (upd_valid)
      nf = (flags & ~upd_mask) | (upd_flags & upd_mask);
    else
      nf = flags;
  end

  // Query sees nf so a same-cycle update or pop is bypassed into the result.
  cond_eval u_cond_eval (
    .cond_code (cond_code),
    .flags     (nf[3:0]),
    .result    (cond_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags       <= '0;
      taken       <= 1'b0;
      taken_valid <= 1'b0;
      stack_cnt   <= '0;
      stack_err   <= 1'b0;
    end else begin
      flags       <= nf;
      taken_valid <= cond_valid;
      if (cond_valid)
        taken <= cond_res;
      stack_err <= op_err;
      if (push_ok)
        stack_cnt <= stack_cnt + CNT_W'(1);
      else if (pop_ok)
        stack_cnt <= stack_cnt - CNT_W'(1);
    end
  end

  // Stack contents need no reset; only the count is architectural.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      stack_mem[wr_idx] <= nf;
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

  logic       clk;
  logic       rst;
  logic       upd_valid;
  logic [3:0] upd_flags;
  logic [3:0] upd_mask;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       push_en;
  logic       pop_en;
  logic [3:0] flags;
  logic       taken;
  logic       taken_valid;
  logic [2:0] stack_cnt;
  logic       stack_err;

  flag_cond_unit #(.STACK_DEPTH(4), .FLAG_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_flags   (upd_flags),
    .upd_mask    (upd_mask),
    .cond_valid  (cond_valid),
    .cond_code   (cond_code),
    .push_en     (push_en),
    .pop_en      (pop_en),
    .flags       (flags),
    .taken       (taken),
    .taken_valid (taken_valid),
    .stack_cnt   (stack_cnt),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic       taken;
    logic       tv;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_stack[$];
  logic [3:0] m_flags;
  logic       m_taken;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Reference condition table, written from the flag meanings.
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of stimulus, predict its outcome, push the prediction,
  // then pop and compare once the DUT has clocked.
  task automatic step(input logic r, input logic uv, input logic [3:0] uf, input logic [3:0] um,
                      input logic cv, input logic [3:0] cc, input logic pu, input logic po);
    exp_t e;
    logic [3:0] nf;
    logic full, empty;
    @(negedge clk);
    rst = r; upd_valid = uv; upd_flags = uf; upd_mask = um;
    cond_valid = cv; cond_code = cc; push_en = pu; pop_en = po;
    if (r) begin
      m_flags = 4'h0; m_taken = 1'b0; m_stack.delete();
      e.flags = 4'h0; e.taken = 1'b0; e.tv = 1'b0; e.cnt = 3'd0; e.err = 1'b0;
    end else begin
      full  = (m_stack.size() == 4);
      empty = (m_stack.size() == 0);
      e.err = (pu && po) || (pu && full) || (po && empty);
      if (po && !pu && !empty)
        nf = m_stack.pop_back();
      else if (uv)
        nf = (m_flags & ~um) | (uf & um);
      else
        nf = m_flags;
      if (pu && !po && !full)
        m_stack.push_back(nf);
      if (cv) m_taken = ref_cond(cc, nf);
      m_flags = nf;
      e.flags = nf; e.taken = m_taken; e.tv = cv;
      e.cnt = 3'(m_stack.size());
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("flags",       32'(flags),       32'(e.flags));
    check_val("taken",       32'(taken),       32'(e.taken));
    check_val("taken_valid", 32'(taken_valid), 32'(e.tv));
    check_val("stack_cnt",   32'(stack_cnt),   32'(e.cnt));
    check_val("stack_err",   32'(stack_err),   32'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_flags = '0; upd_mask = '0;
    cond_valid = 1'b0; cond_code = '0; push_en = 1'b0; pop_en = 1'b0;
    m_flags = '0; m_taken = 1'b0;

    // 1. reset (with competing inputs) then full update
    step(1, 1, 4'hF, 4'hF, 1, 4'd14, 1, 0);
    step(1, 0, 4'h0, 4'h0, 0, 4'd0,  0, 0);
    step(0, 1, 4'hF, 4'hF, 0, 4'd0,  0, 0);
    // 2. masked TST update preserves C and V
    step(0, 1, 4'b0011, 4'hF, 0, 4'd0, 0, 0);
    step(0, 1, 4'b0100, 4'b1100, 0, 4'd0, 0, 0);
    // 3. bypass queries
    step(0, 1, 4'b0100, 4'b0100, 1, 4'd0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 0, 4'd1, 0, 0);   // taken holds
    step(0, 1, 4'b1000, 4'hF, 1, 4'd10, 0, 0);
    step(0, 0, 4'h0, 4'h0, 1, 4'd11, 0, 0);
    // 4. fill, overflow, drain, underflow
    for (int unsigned i = 1; i <= 5; i++)
      step(0, 1, 4'(i), 4'hF, 0, 4'd0, 1, 0);
    step(0, 0, 4'h0, 4'h0, 0, 4'd0, 0, 0);
    for (int unsigned i = 0; i < 5; i++)
      step(0, 0, 4'h0, 4'h0, 1, 4'd2, 0, 1);
    // pop with empty stack and an update: update still applies
    step(0, 1, 4'h9, 4'hF, 0, 4'd0, 0, 1);
    // 5. pop vs update collision, then push+pop together
    step(0, 1, 4'b1000, 4'hF, 0, 4'd0, 1, 0);
    step(0, 1, 4'h2, 4'hF, 0, 4'd0, 1, 0);
    step(0, 1, 4'h3, 4'hF, 0, 4'd0, 0, 0);
    step(0, 1, 4'b0110, 4'hF, 1, 4'd4, 0, 1); // pops 2
    step(0, 1, 4'b0110, 4'hF, 1, 4'd4, 0, 1); // pops 1000
    step(0, 1, 4'h1, 4'hF, 0, 4'd0, 1, 0);
    step(0, 1, 4'h5, 4'hF, 0, 4'd0, 1, 1);
    // reset mid-sequence with a query pending
    step(1, 1, 4'hF, 4'hF, 1, 4'd14, 0, 1);
    step(0, 0, 4'h0, 4'h0, 0, 4'd0, 0, 0);
    // 6. full sweep, back-to-back, via bypassed updates
    for (int unsigned c = 0; c < 16; c++)
      for (int unsigned f = 0; f < 16; f++)
        step(0, 1, 4'(f), 4'hF, 1, 4'(c), 0, 0);
    // sweep again without updates to exercise the registered-flag path
    for (int unsigned c = 0; c < 16; c++) begin
      step(0, 1, 4'(c ^ 4'h5), 4'hF, 0, 4'd0, 0, 0);
      step(0, 0, 4'h0, 4'h0, 1, 4'(c), 0, 0);
    end
    step(0, 0, 4'h0, 4'h0, 0, 4'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
